int_sync_crossing_source_vec: RTL and testbench



---
 rtl/intsync_pkg.sv | 14 +
 rtl/intsync_src_chan.sv | 80 ++++++++
 rtl/int_sync_crossing_source_vec.sv | 31 +++
 tb/tb_int_sync_crossing_source_vec.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/intsync_pkg.sv
// rtl/intsync_pkg.sv - shared constants and helpers for the interrupt sync-crossing source
package intsync_pkg;

  localparam logic INT_MODE_LEVEL = 1'b0;
  localparam logic INT_MODE_EDGE  = 1'b1;

  // Filter counter width: clog2(FILTER_CYCLES+1), never below one bit.
  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = $clog2(filter_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/intsync_src_chan.sv
// rtl/intsync_src_chan.sv - one interrupt channel: stability filter, edge latch, output flop
module intsync_src_chan
  import intsync_pkg::*;
#(
  parameter int FILTER_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic in_i,
  input  logic mode_i,
  input  logic clear_i,
  output logic out_o,
  output logic pend_o
);

  logic f_q, f_d;
  logic pend_q, pend_d;
  logic o_q, o_d;
  logic rise;

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      always_comb f_d = in_i;
    end else begin : g_filt
      localparam int CNT_W = cnt_width(FILTER_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      // A candidate change must persist FILTER_CYCLES samples; any return to
      // the filtered level drops the count back to zero.
      always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (in_i != f_q) begin
          if (cnt_q == CNT_LAST) begin
            f_d = in_i;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Set beats clear when both land in the same cycle.
  always_comb begin
    rise   = f_d & ~f_q;
    pend_d = 1'b0;
    if (mode_i == INT_MODE_EDGE) begin
      pend_d = rise | (pend_q & ~clear_i);
    end
    o_d = (mode_i == INT_MODE_EDGE) ? pend_d : f_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_q    <= 1'b0;
      pend_q <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      f_q    <= f_d;
      pend_q <= pend_d;
      o_q    <= o_d;
    end
  end

  assign out_o  = o_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/int_sync_crossing_source_vec.sv
// rtl/int_sync_crossing_source_vec.sv - multi-channel registered interrupt source for a sync crossing
module int_sync_crossing_source_vec
  import intsync_pkg::*;
#(
  parameter int NUM_INT       = 1,
  parameter int FILTER_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] auto_in,
  input  logic [NUM_INT-1:0] io_mode,
  input  logic [NUM_INT-1:0] io_clear,
  output logic [NUM_INT-1:0] auto_out_sync,
  output logic [NUM_INT-1:0] io_pending
);

  for (genvar i = 0; i < NUM_INT; i++) begin : g_chan
    intsync_src_chan #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .in_i    (auto_in[i]),
      .mode_i  (io_mode[i]),
      .clear_i (io_clear[i]),
      .out_o   (auto_out_sync[i]),
      .pend_o  (io_pending[i])
    );
  end

endmodule

// File: tb/tb_int_sync_crossing_source_vec.sv
// tb/tb_int_sync_crossing_source_vec.sv - directed self-checking bench for int_sync_crossing_source_vec
module tb_int_sync_crossing_source_vec;
  import intsync_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] in0, mode0, clr0, out0, pend0;
  logic [3:0] in3, mode3, clr3, out3, pend3;

  int checks = 0;
  int failures = 0;

  int_sync_crossing_source_vec #(.NUM_INT(4), .FILTER_CYCLES(0)) u_dut0 (
    .clock         (clock),
    .reset         (reset),
    .auto_in       (in0),
    .io_mode       (mode0),
    .io_clear      (clr0),
    .auto_out_sync (out0),
    .io_pending    (pend0)
  );

  int_sync_crossing_source_vec #(.NUM_INT(4), .FILTER_CYCLES(3)) u_dut3 (
    .clock         (clock),
    .reset         (reset),
    .auto_in       (in3),
    .io_mode       (mode3),
    .io_clear      (clr3),
    .auto_out_sync (out3),
    .io_pending    (pend3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in0 = '0; mode0 = {4{INT_MODE_LEVEL}}; clr0 = '0;
    in3 = '0; mode3 = {4{INT_MODE_LEVEL}}; clr3 = '0;
    #2;
    check("rst_out0", out0, 4'h0);
    check("rst_pend0", pend0, 4'h0);
    check("rst_out3", out3, 4'h0);
    step();
    step();
    reset = 1'b0;
    step();

    // level pass-through, K=0
    in0 = 4'b0101;
    step();
    check("lvl_out", out0, 4'b0101);
    check("lvl_pend", pend0, 4'h0);
    in0 = 4'b0000;
    step();
    check("lvl_fall", out0, 4'h0);

    // edge latch and clear, K=0
    mode0 = 4'hF;
    step();
    check("edge_idle", out0, 4'h0);
    in0 = 4'b0100;
    step();
    check("edge_out", out0, 4'b0100);
    check("edge_pend", pend0, 4'b0100);
    in0 = 4'b0000;
    for (int i = 0; i < 10; i++) step();
    check("edge_hold_out", out0, 4'b0100);
    check("edge_hold_pend", pend0, 4'b0100);
    clr0 = 4'b0100;
    step();
    clr0 = 4'b0000;
    check("clr_out", out0, 4'h0);
    check("clr_pend", pend0, 4'h0);
    clr0 = 4'hF;
    step();
    clr0 = 4'h0;
    check("clr_none", {out0, pend0}, 8'h00);

    // rise and clear in the same cycle: set wins
    in0 = 4'b0100;
    step();
    in0 = 4'b0000;
    step();
    check("pre_sc_pend", pend0, 4'b0100);
    in0 = 4'b0100;
    clr0 = 4'b0100;
    step();
    clr0 = 4'b0000;
    in0 = 4'b0000;
    check("sc_pend", pend0, 4'b0100);
    check("sc_out", out0, 4'b0100);
    step();
    check("sc_hold", pend0, 4'b0100);
    clr0 = 4'b0100;
    step();
    clr0 = 4'b0000;
    check("sc_clr", pend0, 4'h0);

    // mode switch on bit 1
    mode0 = 4'b0000;
    in0 = 4'b0010;
    step();
    check("ms_lvl", out0, 4'b0010);
    mode0 = 4'b0010;
    step();
    check("ms_edge_out", out0, 4'h0);
    check("ms_edge_pend", pend0, 4'h0);
    in0 = 4'b0000;
    step();
    in0 = 4'b0010;
    step();
    check("ms_rise_out", out0, 4'b0010);
    check("ms_rise_pend", pend0, 4'b0010);
    mode0 = 4'b0000;
    step();
    check("ms_back_out", out0, 4'b0010);
    check("ms_back_pend", pend0, 4'h0);

    // K=3 filter: 2-cycle glitch rejected
    in3 = 4'b0001;
    step(); check("g_c1", out3, 4'h0);
    step(); check("g_c2", out3, 4'h0);
    in3 = 4'b0000;
    step(); check("g_c3", out3, 4'h0);
    step(); check("g_c4", out3, 4'h0);

    // K=3 filter: 3-cycle pulse accepted for 3 cycles
    in3 = 4'b0001;
    step(); check("p_c1", out3, 4'h0);
    step(); check("p_c2", out3, 4'h0);
    step(); check("p_c3", out3, 4'b0001);
    in3 = 4'b0000;
    step(); check("p_c4", out3, 4'b0001);
    step(); check("p_c5", out3, 4'b0001);
    step(); check("p_c6", out3, 4'h0);

    // async reset mid-count and with pending set
    in3 = 4'b0010;
    step(); step(); step();
    check("r_pre_out3", out3, 4'b0010);
    in3 = 4'b0011;
    mode0 = 4'b1000;
    in0 = 4'b1000;
    step();
    check("r_pre_pend0", pend0, 4'b1000);
    step();
    #3;
    reset = 1'b1;
    #1;
    check("r_async_out0", out0, 4'h0);
    check("r_async_pend0", pend0, 4'h0);
    check("r_async_out3", out3, 4'h0);
    step();
    reset = 1'b0;
    step(); check("r_k1", out3, 4'h0);
    step(); check("r_k2", out3, 4'h0);
    step(); check("r_k3", out3, 4'b0011);
    check("r_pend3", pend3, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
